// File: rtl/vga_timing_pkg.sv
// Shared timing constants, count type and flag payload for the VGA raster generator.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  // 640x480@60 industry timing, 25 MHz pixel clock
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Image window that gates ROM address increments (200x200 = 40000 words)
  localparam int unsigned IMG_X0_DEF = 0;
  localparam int unsigned IMG_Y0_DEF = 0;
  localparam int unsigned IMG_W_DEF  = 200;
  localparam int unsigned IMG_H_DEF  = 200;

  localparam int unsigned ROM_AW = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  // Per-pixel decoded flags, registered together with the counts
  typedef struct packed {
    logic enable_h;
    logic enable_v;
    logic display_active;
    logic hsync;
    logic vsync;
  } vga_flags_t;

  // Half-open window test [lo, lo+len), done in 32 bits so lo+len may reach 2**CNT_W
  function automatic logic in_window(cnt_t val, int unsigned lo, int unsigned len);
    int unsigned v32;
    v32 = 32'(val);
    return (v32 >= lo) && (v32 < lo + len);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: modulo-TOTAL counter advancing on carry_in, exposing its next value.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = H_TOTAL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic carry_in,
  output cnt_t count,
  output cnt_t count_next_c,
  output logic wrap_c
);

  // Next count: wrap to zero at TOTAL-1, otherwise increment on carry, else hold
  always_comb begin
    wrap_c       = carry_in && (count == CNT_W'(TOTAL - 1));
    count_next_c = count;
    if (wrap_c) begin
      count_next_c = '0;
    end else if (carry_in) begin
      count_next_c = count + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator: counts, syncs, display/window enables, frame pulse.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned IMG_X0   = IMG_X0_DEF,
  parameter int unsigned IMG_Y0   = IMG_Y0_DEF,
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned IMG_H    = IMG_H_DEF
) (
  input  logic             clk_25M,
  input  logic             rst_n,
  input  logic             tick_en,
  output logic [CNT_W-1:0] H_Count_Value,
  output logic [CNT_W-1:0] V_Count_Value,
  output logic             enable_horizontal,
  output logic             enable_vertical,
  output logic             display_active,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Parameter sanity: counts fit CNT_W, window inside active area, window fits ROM
  if (H_TOTAL > (1 << CNT_W)) begin : g_chk_h_total
    $error("H_TOTAL %0d exceeds count range", H_TOTAL);
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_chk_v_total
    $error("V_TOTAL %0d exceeds count range", V_TOTAL);
  end
  if (IMG_X0 + IMG_W > H_ACTIVE) begin : g_chk_img_x
    $error("image window exceeds horizontal active area");
  end
  if (IMG_Y0 + IMG_H > V_ACTIVE) begin : g_chk_img_y
    $error("image window exceeds vertical active area");
  end
  if (IMG_W * IMG_H > (1 << ROM_AW)) begin : g_chk_img_size
    $error("image window exceeds ROM address space");
  end

  cnt_t       h_cnt;
  cnt_t       h_next_c;
  logic       h_wrap_c;
  cnt_t       v_cnt;
  cnt_t       v_next_c;
  logic       v_wrap_c;
  vga_flags_t flags_d_c;
  vga_flags_t flags_q;
  logic       frame_start_q;

  // Horizontal axis advances on every enabled pixel tick
  vga_axis_counter #(
    .TOTAL(H_TOTAL)
  ) u_h_counter (
    .clk         (clk_25M),
    .rst_n       (rst_n),
    .carry_in    (tick_en),
    .count       (h_cnt),
    .count_next_c(h_next_c),
    .wrap_c      (h_wrap_c)
  );

  // Vertical axis advances on each horizontal wrap
  vga_axis_counter #(
    .TOTAL(V_TOTAL)
  ) u_v_counter (
    .clk         (clk_25M),
    .rst_n       (rst_n),
    .carry_in    (h_wrap_c),
    .count       (v_cnt),
    .count_next_c(v_next_c),
    .wrap_c      (v_wrap_c)
  );

  // Flags for a given raster position; syncs are active low
  function automatic vga_flags_t decode(cnt_t h, cnt_t v);
    vga_flags_t f;
    f.enable_h       = in_window(h, IMG_X0, IMG_W);
    f.enable_v       = in_window(v, IMG_Y0, IMG_H);
    f.display_active = in_window(h, 0, H_ACTIVE) && in_window(v, 0, V_ACTIVE);
    f.hsync          = !in_window(h, H_ACTIVE + H_FP, H_SYNC);
    f.vsync          = !in_window(v, V_ACTIVE + V_FP, V_SYNC);
    return f;
  endfunction

  // Decode from next counts so registered flags line up with registered counts
  always_comb begin
    flags_d_c = decode(h_next_c, v_next_c);
  end

  // Flag and frame-pulse registers; pulse only on a real (H,V) wrap with tick_en high
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      flags_q       <= decode('0, '0);
      frame_start_q <= 1'b0;
    end else begin
      flags_q       <= flags_d_c;
      frame_start_q <= v_wrap_c;
    end
  end

  assign H_Count_Value     = h_cnt;
  assign V_Count_Value     = v_cnt;
  assign enable_horizontal = flags_q.enable_h;
  assign enable_vertical   = flags_q.enable_v;
  assign display_active    = flags_q.display_active;
  assign hsync             = flags_q.hsync;
  assign vsync             = flags_q.vsync;
  assign frame_start       = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: standard 640x480 instance plus a shrunken-timing instance for full frames.
module tb_vga_timing_gen;

  // Shrunken timing so whole frames, vsync and frame wraps fit a short run
  localparam int unsigned B_HA = 20, B_HF = 2, B_HS = 4, B_HB = 4;
  localparam int unsigned B_VA = 12, B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int unsigned B_IX = 3, B_IY = 2, B_IW = 8, B_IH = 6;

  // Reference timing per instance: [0] standard, [1] small
  int p_ha[2]  = '{640, B_HA};
  int p_hf[2]  = '{16,  B_HF};
  int p_hsw[2] = '{96,  B_HS};
  int p_hb[2]  = '{48,  B_HB};
  int p_va[2]  = '{480, B_VA};
  int p_vf[2]  = '{10,  B_VF};
  int p_vsw[2] = '{2,   B_VS};
  int p_vb[2]  = '{33,  B_VB};
  int p_ix[2]  = '{0,   B_IX};
  int p_iy[2]  = '{0,   B_IY};
  int p_iw[2]  = '{200, B_IW};
  int p_ih[2]  = '{200, B_IH};

  logic       clk_25M = 1'b0;
  logic       rst_n   [2];
  logic       tick_en [2];
  logic [9:0] h_cnt   [2];
  logic [9:0] v_cnt   [2];
  logic       en_h    [2];
  logic       en_v    [2];
  logic       disp    [2];
  logic       hsync   [2];
  logic       vsync   [2];
  logic       fstart  [2];

  // Reference state: linear pixel position within the frame and expected pulse
  int pos    [2];
  bit fs_exp [2];

  int checks = 0;
  int errors = 0;

  always #20 clk_25M = ~clk_25M;

  vga_timing_gen u_dut_std (
    .clk_25M          (clk_25M),
    .rst_n            (rst_n[0]),
    .tick_en          (tick_en[0]),
    .H_Count_Value    (h_cnt[0]),
    .V_Count_Value    (v_cnt[0]),
    .enable_horizontal(en_h[0]),
    .enable_vertical  (en_v[0]),
    .display_active   (disp[0]),
    .hsync            (hsync[0]),
    .vsync            (vsync[0]),
    .frame_start      (fstart[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .IMG_X0(B_IX), .IMG_Y0(B_IY), .IMG_W(B_IW), .IMG_H(B_IH)
  ) u_dut_small (
    .clk_25M          (clk_25M),
    .rst_n            (rst_n[1]),
    .tick_en          (tick_en[1]),
    .H_Count_Value    (h_cnt[1]),
    .V_Count_Value    (v_cnt[1]),
    .enable_horizontal(en_h[1]),
    .enable_vertical  (en_v[1]),
    .display_active   (disp[1]),
    .hsync            (hsync[1]),
    .vsync            (vsync[1]),
    .frame_start      (fstart[1])
  );

  function automatic int htot(int i);
    return p_ha[i] + p_hf[i] + p_hsw[i] + p_hb[i];
  endfunction

  function automatic int vtot(int i);
    return p_va[i] + p_vf[i] + p_vsw[i] + p_vb[i];
  endfunction

  function automatic int frame_len(int i);
    return htot(i) * vtot(i);
  endfunction

  function automatic bit rand_tick();
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output of one instance against the position-derived expectation
  task automatic compare_all(input int i);
    int    h;
    int    v;
    string t;
    h = pos[i] % htot(i);
    v = pos[i] / htot(i);
    t = (i == 0) ? "std" : "small";
    check({t, ".h"},      int'(h_cnt[i]), h);
    check({t, ".v"},      int'(v_cnt[i]), v);
    check({t, ".en_h"},   int'(en_h[i]),  int'(h >= p_ix[i] && h < p_ix[i] + p_iw[i]));
    check({t, ".en_v"},   int'(en_v[i]),  int'(v >= p_iy[i] && v < p_iy[i] + p_ih[i]));
    check({t, ".disp"},   int'(disp[i]),  int'(h < p_ha[i] && v < p_va[i]));
    check({t, ".hsync"},  int'(hsync[i]),
          int'(!(h >= p_ha[i] + p_hf[i] && h < p_ha[i] + p_hf[i] + p_hsw[i])));
    check({t, ".vsync"},  int'(vsync[i]),
          int'(!(v >= p_va[i] + p_vf[i] && v < p_va[i] + p_vf[i] + p_vsw[i])));
    check({t, ".fstart"}, int'(fstart[i]), int'(fs_exp[i]));
  endtask

  // One clock: drive ticks, advance the reference on the edge, compare both instances
  task automatic step(input bit ta, input bit tb);
    tick_en[0] = ta;
    tick_en[1] = tb;
    @(posedge clk_25M);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        pos[i]    = 0;
        fs_exp[i] = 1'b0;
      end else if (tick_en[i]) begin
        fs_exp[i] = (pos[i] == frame_len(i) - 1);
        pos[i]    = (pos[i] + 1) % frame_len(i);
      end else begin
        fs_exp[i] = 1'b0;
      end
    end
    #5;
    compare_all(0);
    compare_all(1);
  endtask

  // Assert reset between clock edges and check outputs return before the next edge
  task automatic async_reset(input int i);
    #10;
    rst_n[i]  = 1'b0;
    pos[i]    = 0;
    fs_exp[i] = 1'b0;
    #2;
    compare_all(i);
    check("async.h", int'(h_cnt[i]), 0);
    check("async.v", int'(v_cnt[i]), 0);
    check("async.fstart", int'(fstart[i]), 0);
    step(1'b1, 1'b1);
    rst_n[i] = 1'b1;
  endtask

  initial begin
    int win_count;
    rst_n   = '{1'b0, 1'b0};
    tick_en = '{1'b0, 1'b0};
    pos     = '{0, 0};
    fs_exp  = '{1'b0, 1'b0};

    repeat (3) @(posedge clk_25M);
    #5;
    compare_all(0);
    compare_all(1);
    check("rst.en_h",   int'(en_h[0]),   1);
    check("rst.en_v",   int'(en_v[0]),   1);
    check("rst.disp",   int'(disp[0]),   1);
    check("rst.hsync",  int'(hsync[0]),  1);
    check("rst.vsync",  int'(vsync[0]),  1);
    check("rst.fstart", int'(fstart[0]), 0);

    // Release mid-cycle; (0,0) shown until the first enabled edge
    rst_n = '{1'b1, 1'b1};
    #2;
    check("release.h", int'(h_cnt[0]), 0);

    // First line of the standard instance, H 0..799 then V steps to 1
    for (int n = 0; n < 800; n++) begin
      step(1'b1, rand_tick());
      if (pos[0] == 199) check("win.h199", int'(en_h[0]), 1);
      if (pos[0] == 200) check("win.h200", int'(en_h[0]), 0);
      if (pos[0] == 656) check("hsync.h656", int'(hsync[0]), 0);
      if (pos[0] == 751) check("hsync.h751", int'(hsync[0]), 0);
      if (pos[0] == 752) check("hsync.h752", int'(hsync[0]), 1);
    end
    check("line.h_wrap", int'(h_cnt[0]), 0);
    check("line.v_step", int'(v_cnt[0]), 1);

    // Hold at H=655 for five cycles, then resume into sync
    while (pos[0] % 800 != 655) step(1'b1, rand_tick());
    repeat (5) step(1'b0, rand_tick());
    check("hold.h", int'(h_cnt[0]), 655);
    check("hold.hsync", int'(hsync[0]), 1);
    step(1'b1, rand_tick());
    check("resume.h", int'(h_cnt[0]), 656);
    check("resume.hsync", int'(hsync[0]), 0);

    // Small instance: reach the frame wrap, then stall on it
    while (pos[1] != frame_len(1) - 1) step(rand_tick(), 1'b1);
    step(rand_tick(), 1'b1);
    check("wrap.fstart", int'(fstart[1]), 1);
    check("wrap.h", int'(h_cnt[1]), 0);
    check("wrap.v", int'(v_cnt[1]), 0);
    repeat (3) step(rand_tick(), 1'b0);
    check("wrap_hold.fstart", int'(fstart[1]), 0);

    // One uninterrupted frame: count image-window pixels
    win_count = 0;
    for (int n = 0; n < frame_len(1); n++) begin
      if (en_h[1] && en_v[1]) win_count++;
      step(rand_tick(), 1'b1);
    end
    check("small.win_count", win_count, int'(B_IW * B_IH));
    check("small.next_fstart", int'(fstart[1]), 1);

    // Randomized tick pattern on both instances
    repeat (3000) step(rand_tick(), rand_tick());

    // Asynchronous reset in mid-line / mid-frame
    while (pos[0] % 800 != 300) step(1'b1, rand_tick());
    async_reset(0);
    while (pos[1] != 7 * htot(1) + 10) step(rand_tick(), 1'b1);
    async_reset(1);

    repeat (300) step(rand_tick(), rand_tick());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
